// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-vector multiply sequencer.
package matmul_pkg;

  typedef enum logic [2:0] {
    S_LOADA = 3'd0,
    S_WAITB = 3'd1,
    S_MAC1  = 3'd2,
    S_MAC2  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [6:0] CH_A    = 7'd0;
  localparam logic [6:0] CH_B    = 7'd1;
  localparam logic [6:0] CH_CMD  = 7'd2;
  localparam logic [6:0] CH_RES  = 7'd8;
  localparam logic [6:0] CH_STAT = 7'd9;

  localparam logic [7:0] CMD_LOADA = 8'h01;
  localparam logic [7:0] CMD_REUSE = 8'h02;

  // Status byte layout, MSB first: state, busy, low nibble of the B index.
  function automatic logic [7:0] status_byte(state_t s, logic busy, logic [3:0] b);
    return {s, busy, b};
  endfunction

endpackage

// File: rtl/matmul_sequencer_result_reader.sv
// Host read side: result row pointer, N_ROWS:1 result mux, ch8/ch9 read data.
module result_reader
  import matmul_pkg::*;
#(
  parameter int N_ROWS = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  state_t                   i_state,
  input  logic [6:0]               i_chan,
  input  logic                     i_f2hReady,
  input  logic                     i_clear,
  input  logic                     i_busy,
  input  logic [3:0]               i_bCnt,
  input  logic [N_ROWS*DATA_W-1:0] i_rowResult,
  output logic [7:0]               o_f2hData,
  output logic                     o_f2hValid
);

  localparam int RCW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  logic [RCW-1:0]    r_rCnt;
  logic [DATA_W-1:0] w_res [N_ROWS];
  logic              w_adv;

  // Split the flat result bus into per-row words.
  for (genvar g = 0; g < N_ROWS; g++) begin : g_res
    assign w_res[g] = i_rowResult[g*DATA_W +: DATA_W];
  end

  // The pointer only moves while results are actually being served on ch8.
  assign w_adv = (i_state == S_DONE) && (i_chan == CH_RES) && i_f2hReady;

  // Result pointer, wrapping at the last row; cleared by host commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_rCnt <= '0;
    else if (i_clear)  r_rCnt <= '0;
    else if (w_adv)    r_rCnt <= (r_rCnt == RCW'(N_ROWS-1)) ? '0 : r_rCnt + 1'b1;
  end

  // Host never stalls on reads, so data is always presented as valid.
  assign o_f2hValid = 1'b1;

  // Zero-latency read data selected by channel and state.
  always_comb begin
    o_f2hData = 8'h00;
    case (i_chan)
      CH_RES:  o_f2hData = (i_state == S_DONE) ? 8'(w_res[r_rCnt]) : 8'hFF;
      CH_STAT: o_f2hData = status_byte(i_state, i_busy, i_bCnt);
      default: o_f2hData = 8'h00;
    endcase
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Autonomous sequencer turning host channel bytes into row-array control:
// A-matrix RAM writes, B-vector MAC steps, accumulator clear, result readout.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int N_ROWS = 16,
  parameter int N_COLS = 16,
  parameter int DATA_W = 8
) (
  input  logic                      fx2Clk_in,
  input  logic                      reset_in,
  input  logic [6:0]                chanAddr_in,
  input  logic [7:0]                h2fData_in,
  input  logic                      h2fValid_in,
  output logic                      h2fReady_out,
  output logic [7:0]                f2hData_out,
  output logic                      f2hValid_out,
  input  logic                      f2hReady_in,
  output logic [N_ROWS-1:0]         rowWe_out,
  output logic [$clog2(N_COLS)-1:0] rowAddr_out,
  output logic [DATA_W-1:0]         rowDin_out,
  output logic [DATA_W-1:0]         vecB_out,
  output logic                      accClear_out,
  output logic                      accEn_out,
  input  logic [N_ROWS*DATA_W-1:0]  rowResult_in,
  output logic                      busy_out
);

  localparam int CW     = $clog2(N_COLS);
  localparam int RW     = $clog2(N_ROWS);
  localparam int KW     = CW + RW;
  localparam int A_LAST = N_ROWS * N_COLS - 1;

  state_t            r_state, w_next;
  logic [KW-1:0]     r_aCnt;
  logic [CW-1:0]     r_bCnt;
  logic [N_ROWS-1:0] r_rowWe;
  logic [CW-1:0]     r_rowAddr;
  logic [DATA_W-1:0] r_rowDin, r_vecB;
  logic              r_accClear;

  logic w_acc, w_aWr, w_bWr, w_cmdLoad, w_cmdReuse, w_aLast, w_bLast;
  logic [N_ROWS-1:0] w_rowSel;

  // Ready/busy are pure functions of state so acceptance never loops back
  // through next-state logic.
  assign busy_out     = (r_state == S_MAC1) || (r_state == S_MAC2);
  assign h2fReady_out = ~busy_out;

  assign w_acc      = h2fValid_in & h2fReady_out;
  assign w_aWr      = w_acc && (chanAddr_in == CH_A) && (r_state == S_LOADA);
  assign w_bWr      = w_acc && (chanAddr_in == CH_B) && (r_state == S_WAITB);
  assign w_cmdLoad  = w_acc && (chanAddr_in == CH_CMD) && (h2fData_in == CMD_LOADA);
  assign w_cmdReuse = w_acc && (chanAddr_in == CH_CMD) && (h2fData_in == CMD_REUSE);
  assign w_aLast    = w_aWr && (r_aCnt == KW'(A_LAST));
  assign w_bLast    = (r_bCnt == CW'(N_COLS-1));
  assign w_rowSel   = N_ROWS'(1) << r_aCnt[KW-1:CW];

  // State register.
  always_ff @(posedge fx2Clk_in or posedge reset_in) begin
    if (reset_in) r_state <= S_LOADA;
    else          r_state <= w_next;
  end

  // Next state and MAC enable; commands override the data-driven path.
  always_comb begin
    w_next    = r_state;
    accEn_out = 1'b0;
    case (r_state)
      S_LOADA: if (w_aLast) w_next = S_WAITB;
      S_WAITB: if (w_bWr)   w_next = S_MAC1;
      S_MAC1:  w_next = S_MAC2;
      S_MAC2: begin
        accEn_out = 1'b1;
        w_next    = w_bLast ? S_DONE : S_WAITB;
      end
      S_DONE:  w_next = S_DONE;
      default: w_next = S_LOADA;
    endcase
    if (w_cmdLoad)       w_next = S_LOADA;
    else if (w_cmdReuse) w_next = S_WAITB;
  end

  // A index: wraps to 0 on the same edge as the final byte.
  always_ff @(posedge fx2Clk_in or posedge reset_in) begin
    if (reset_in)       r_aCnt <= '0;
    else if (w_cmdLoad) r_aCnt <= '0;
    else if (w_aWr)     r_aCnt <= r_aCnt + 1'b1;
  end

  // B index: restarts whenever a fresh MAC pass begins, advances per MAC.
  always_ff @(posedge fx2Clk_in or posedge reset_in) begin
    if (reset_in)                              r_bCnt <= '0;
    else if (w_cmdLoad || w_cmdReuse || w_aLast) r_bCnt <= '0;
    else if (r_state == S_MAC2)                r_bCnt <= r_bCnt + 1'b1;
  end

  // Registered row-array drive; write enable is a single-cycle strobe.
  always_ff @(posedge fx2Clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_rowWe    <= '0;
      r_rowAddr  <= '0;
      r_rowDin   <= '0;
      r_vecB     <= '0;
      r_accClear <= 1'b0;
    end else begin
      r_rowWe    <= w_aWr ? w_rowSel : '0;
      r_accClear <= w_aLast | w_cmdReuse;
      if (w_aWr) begin
        r_rowAddr <= r_aCnt[CW-1:0];
        r_rowDin  <= DATA_W'(h2fData_in);
      end else if (w_bWr) begin
        r_rowAddr <= r_bCnt;
        r_vecB    <= DATA_W'(h2fData_in);
      end
    end
  end

  assign rowWe_out    = r_rowWe;
  assign rowAddr_out  = r_rowAddr;
  assign rowDin_out   = r_rowDin;
  assign vecB_out     = r_vecB;
  assign accClear_out = r_accClear;

  result_reader #(
    .N_ROWS (N_ROWS),
    .DATA_W (DATA_W)
  ) u_result_reader (
    .clk         (fx2Clk_in),
    .rst         (reset_in),
    .i_state     (r_state),
    .i_chan      (chanAddr_in),
    .i_f2hReady  (f2hReady_in),
    .i_clear     (w_cmdLoad | w_cmdReuse),
    .i_busy      (busy_out),
    .i_bCnt      (4'(r_bCnt)),
    .i_rowResult (rowResult_in),
    .o_f2hData   (f2hData_out),
    .o_f2hValid  (f2hValid_out)
  );

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer with a behavioural 16-row array attached.
module tb_matmul_sequencer;

  localparam int NR = 16;
  localparam int NC = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    chan = '0;
  logic [7:0]    hdata = '0;
  logic          hvalid = 1'b0;
  logic          hready;
  logic [7:0]    fdata;
  logic          fvalid;
  logic          fready = 1'b0;
  logic [NR-1:0] rowWe;
  logic [3:0]    rowAddr;
  logic [7:0]    rowDin, vecB;
  logic          accClear, accEn, busy;
  logic [NR*8-1:0] rowResult;

  int n_chk = 0;
  int n_err = 0;
  int nWe = 0, nEn = 0, nClr = 0;

  logic [7:0] A [NR][NC];
  logic [7:0] B [NC];
  logic [7:0] q [$];

  // Row array model: 1-cycle read RAM plus modulo-256 accumulator per row.
  logic [7:0] ram [NR][NC];
  logic [7:0] rd  [NR];
  logic [7:0] acc [NR];

  always #5 clk = ~clk;

  matmul_sequencer #(.N_ROWS(NR), .N_COLS(NC), .DATA_W(8)) dut (
    .fx2Clk_in    (clk),
    .reset_in     (rst),
    .chanAddr_in  (chan),
    .h2fData_in   (hdata),
    .h2fValid_in  (hvalid),
    .h2fReady_out (hready),
    .f2hData_out  (fdata),
    .f2hValid_out (fvalid),
    .f2hReady_in  (fready),
    .rowWe_out    (rowWe),
    .rowAddr_out  (rowAddr),
    .rowDin_out   (rowDin),
    .vecB_out     (vecB),
    .accClear_out (accClear),
    .accEn_out    (accEn),
    .rowResult_in (rowResult),
    .busy_out     (busy)
  );

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (rowWe[i]) ram[i][rowAddr] <= rowDin;
      rd[i] <= ram[i][rowAddr];
      if (accClear)   acc[i] <= 8'h00;
      else if (accEn) acc[i] <= acc[i] + 8'(rd[i] * vecB);
    end
    nWe <= nWe + $countones(rowWe);
    if (accEn)    nEn  <= nEn + 1;
    if (accClear) nClr <= nClr + 1;
  end

  always_comb begin
    rowResult = '0;
    for (int i = 0; i < NR; i++) rowResult[i*8 +: 8] = acc[i];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [6:0] ch, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!hready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!hready) chk("send_ready_timeout", 32'(hready), 32'd1);
    chan = ch; hdata = d; hvalid = 1'b1;
    @(posedge clk);
    #1 hvalid = 1'b0;
  endtask

  task automatic rd_byte(input logic [6:0] ch, input logic adv, output logic [7:0] d);
    @(negedge clk);
    chan = ch; fready = adv;
    #1 d = fdata;
    @(posedge clk);
    #1 fready = 1'b0;
  endtask

  task automatic chk_stat(input string tag, input logic [7:0] exp);
    logic [7:0] d;
    rd_byte(7'd9, 1'b0, d);
    chk(tag, 32'(d), 32'(exp));
  endtask

  task automatic load_a();
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < NC; j++) send(7'd0, A[i][j]);
  endtask

  // Sends B; expected dot products are queued as the last element goes out.
  task automatic run_b();
    logic [7:0] e;
    for (int j = 0; j < NC; j++) begin
      send(7'd1, B[j]);
      if (j == NC-1)
        for (int i = 0; i < NR; i++) begin
          e = 8'h00;
          for (int k = 0; k < NC; k++) e = e + 8'(A[i][k] * B[k]);
          q.push_back(e);
        end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    logic [7:0] d, e;
    for (int k = 0; k < n; k++) begin
      rd_byte(7'd8, 1'b1, d);
      if (q.size() == 0) chk("res_queue_empty", 32'(q.size()), 32'd1);
      else begin
        e = q.pop_front();
        chk("res", 32'(d), 32'(e));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int we0, en0, clr0;
    logic [7:0] d;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",  32'(hready),   32'd1);
    chk("rst_fvalid", 32'(fvalid),   32'd1);
    chk("rst_we",     32'(rowWe),    32'd0);
    chk("rst_addr",   32'(rowAddr),  32'd0);
    chk("rst_din",    32'(rowDin),   32'd0);
    chk("rst_vecb",   32'(vecB),     32'd0);
    chk("rst_clr",    32'(accClear), 32'd0);
    chk("rst_en",     32'(accEn),    32'd0);
    chk("rst_busy",   32'(busy),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_stat("rst_stat", 8'h00);

    // All-ones A, B=2; plus stray bytes in the wrong states.
    for (int i = 0; i < NR; i++) for (int j = 0; j < NC; j++) A[i][j] = 8'h01;
    for (int j = 0; j < NC; j++) B[j] = 8'h02;
    we0 = nWe; en0 = nEn; clr0 = nClr;
    send(7'd1, 8'h55);
    repeat (2) @(posedge clk);
    #1;
    chk("stray_b_en", 32'(nEn - en0), 32'd0);
    chk("stray_b_we", 32'(nWe - we0), 32'd0);
    chk_stat("stray_b_stat", 8'h00);
    rd_byte(7'd8, 1'b0, d);
    chk("early_res", 32'(d), 32'hFF);
    load_a();
    repeat (2) @(posedge clk);
    #1;
    chk("a_we_count", 32'(nWe - we0), 32'd256);
    chk_stat("waitb_stat", 8'h20);
    send(7'd0, 8'h77);
    repeat (2) @(posedge clk);
    #1;
    chk("stray_a_we", 32'(nWe - we0), 32'd256);
    chk_stat("stray_a_stat", 8'h20);
    send(7'd1, B[0]);
    chk("mac1_busy",  32'(busy),   32'd1);
    chk("mac1_ready", 32'(hready), 32'd0);
    for (int j = 1; j < NC; j++) send(7'd1, B[j]);
    for (int i = 0; i < NR; i++) q.push_back(8'h20);
    repeat (3) @(posedge clk);
    #1;
    chk("en_count",  32'(nEn - en0),  32'd16);
    chk("clr_count", 32'(nClr - clr0), 32'd1);
    chk_stat("done_stat", 8'h80);
    drain(NR);

    // Identity A, B=j+1; the 17th read wraps to row 0.
    send(7'd2, 8'h01);
    chk_stat("loada_stat", 8'h00);
    for (int i = 0; i < NR; i++) for (int j = 0; j < NC; j++) A[i][j] = (i == j) ? 8'h01 : 8'h00;
    for (int j = 0; j < NC; j++) B[j] = 8'(j + 1);
    load_a();
    run_b();
    q.push_back(8'h01);
    drain(NR + 1);
    send(7'd2, 8'h05);
    chk_stat("bad_cmd_stat", 8'h80);

    // Reuse identity A with B all ones.
    clr0 = nClr;
    send(7'd2, 8'h02);
    for (int j = 0; j < NC; j++) B[j] = 8'h01;
    run_b();
    chk("reuse_clr", 32'(nClr - clr0), 32'd1);
    drain(NR);

    // All 0xFF operands.
    send(7'd2, 8'h01);
    for (int i = 0; i < NR; i++) for (int j = 0; j < NC; j++) A[i][j] = 8'hFF;
    for (int j = 0; j < NC; j++) B[j] = 8'hFF;
    load_a();
    run_b();
    chk("ff_expect", 32'(q[0]), 32'h10);
    drain(NR);

    // Reset during MAC1 aborts the step.
    send(7'd2, 8'h02);
    send(7'd1, 8'h03);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    en0 = nEn;
    rst = 1'b1;
    #1;
    chk("rst_mac_ready", 32'(hready), 32'd1);
    chk("rst_mac_en",    32'(accEn),  32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mac_en_cnt", 32'(nEn - en0), 32'd0);
    chk_stat("rst_mac_stat", 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Sequencer for the 16-row parallel matrix-vector multiply array: it converts host channel traffic into the row-unit control sequence (A-matrix RAM writes, B-vector MAC steps, accumulator clear, result readout). It replaces host-driven state/index registers with an autonomous FSM and sits between `comm_fpga_fx2` and the row array. Each row unit has a 16x8 RAM with 1-cycle read latency and an 8-bit accumulator.

## Interface
- `N_ROWS`, default 16: number of row units.
- `N_COLS`, default 16: elements per row, which is also the B length.
- `DATA_W`, default 8: element and accumulator width.
- `fx2Clk_in` in 1: 48 MHz system clock.
- `reset_in` in 1: reset, asynchronous, active-high.
- `chanAddr_in` in 7: selected host channel.
- `h2fData_in` in 8: host write data.
- `h2fValid_in` in 1: host byte present.
- `h2fReady_out` out 1: sequencer accepts a byte. A transfer occurs on an edge with valid & ready.
- `f2hData_out` out 8: host read data.
- `f2hValid_out` out 1: read data valid.
- `f2hReady_in` in 1: host consumes a byte this edge.
- `rowWe_out` out N_ROWS: one-hot RAM write enable.
- `rowAddr_out` out 4: RAM address, shared by all rows.
- `rowDin_out` out 8: RAM write data.
- `vecB_out` out 8: current B element.
- `accClear_out` out 1: clear all accumulators.
- `accEn_out` out 1: every row adds `ram*vecB` this edge.
- `rowResult_in` in N_ROWS*8: row i result on bits [8i+7:8i].
- `busy_out` out 1: high in S_MAC.

## Operation
- Channel map:
  - ch0: A data (row-major, 256 bytes).
  - ch1: B data.
  - ch2: command.
  - ch8: result read.
  - ch9: status read.
- States: S_LOADA, S_WAITB, S_MAC1, S_MAC2, S_DONE.
- S_LOADA:
  - Each accepted ch0 byte k (counter aCnt, 0..255) writes row k/16, address k%16.
  - When k=255, go to S_WAITB, pulse accClear_out, and set bCnt=0.
- S_WAITB, accepted ch1 byte j = bCnt:
  - Register vecB_out and rowAddr_out=j.
  - Transition S_MAC1 -> S_MAC2 -> S_WAITB, with accEn_out high for exactly one cycle, in S_MAC2.
  - bCnt then increments. After the MAC for j=N_COLS-1, go to S_DONE instead of S_WAITB.
- S_DONE:
  - ch8 returns rowResult[rCnt] with f2hValid_out=1.
  - rCnt advances on each f2hReady_in and wraps 15->0.
- ch8 outside S_DONE: return 0xFF, valid=1 (the host never stalls).
- ch9, any state: return {state[2:0], busy, bCnt[3:0]} (MSB first).
- Commands (ch2):
  - 0x01: go to S_LOADA, clear aCnt, bCnt and rCnt.
  - 0x02: reuse A. Go to S_WAITB, pulse accClear_out, clear bCnt and rCnt.
  - Any other value is ignored.
- Out-of-place bytes: ch0 outside S_LOADA, ch1 outside S_WAITB, and all other channels are accepted and discarded.
- Arithmetic is modulo 2^8 in the rows; the sequencer performs no arithmetic on data.

## Timing
- h2fReady_out = 0 in S_MAC1/S_MAC2, 1 otherwise. It is combinational from state.
- A write: byte accepted at edge T. rowWe_out, rowAddr_out and rowDin_out are registered and valid for the single cycle after T. The RAM writes at edge T+1.
- B step:
  - Byte accepted at edge T.
  - rowAddr_out and vecB_out are valid from T+1 (S_MAC1).
  - RAM output is valid in S_MAC2, where accEn_out=1.
  - The accumulate happens at edge T+2.
  - Throughput: 1 B byte per 3 cycles.
- accClear_out is a 1-cycle pulse in the cycle after the triggering acceptance. It never coincides with accEn_out.
- f2hData_out is combinational from rCnt and state. It has zero latency.
- Reset values:
  - State S_LOADA, all counters 0.
  - rowWe_out=0, rowAddr_out=0, rowDin_out=0, vecB_out=0.
  - accClear_out=0, accEn_out=0, busy_out=0.
  - h2fReady_out=1, f2hValid_out=1.
- Reset mid-MAC aborts the step with no accEn pulse. Reset mid-write suppresses rowWe immediately (asynchronous).
- aCnt wraps only via the transition to S_WAITB. The 256th byte and the transition occur on the same edge.

## Structure
- Package `matmul_pkg`: state enum, channel constants CH_A=0, CH_B=1, CH_CMD=2, CH_RES=8, CH_STAT=9, command codes CMD_LOADA=0x01, CMD_REUSE=0x02.
- One natural sub-module: `result_reader`. It holds rCnt, the N_ROWS:1 result mux and the ch8/ch9 f2h logic.

## Test plan
- Load A with A[i][j]=1, B all 2 -> every result reads 32 (0x20). Exactly 256 rowWe pulses occur; accEn pulses exactly 16 times.
- A = identity, B[j]=j+1 -> ch8 reads 1,2,…,16, then wraps to 1 on the 17th read.
- A all 0xFF, B all 0xFF -> each result = (16*0xFE01) mod 256 = 0x10.
- Send a ch1 byte during S_LOADA and a ch0 byte during S_WAITB -> both ignored, no rowWe/accEn, counters unchanged. Send ch8 before S_DONE -> reads 0xFF.
- After S_DONE, send cmd 0x02 plus new B all 1 with identity A -> accClear pulse once; results become 1.
- Assert reset_in during S_MAC1 -> no accEn pulse. Status reads state S_LOADA, bCnt 0; h2fReady_out=1 immediately.
